// File: rtl/snn_neuron_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron array.
//   state_t  : sweep FSM encoding (ACCUM, SWEEP, SPIKE_WAIT)
//   sat_add  : signed add clamped to a w-bit two's complement range
//   leak     : one decay step, v - (v >>> shift)
// Both helpers work on a 64-bit signed carrier, so callers sign-extend
// their W-bit operands (W <= 63) and truncate the result back to W bits.
package snn_neuron_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM      = 2'd0,
        ST_SWEEP      = 2'd1,
        ST_SPIKE_WAIT = 2'd2
    } state_t;

    localparam int XW = 64;

    function automatic logic signed [XW-1:0] sat_add(
        input logic signed [XW-1:0] a,
        input logic signed [XW-1:0] b,
        input int                   w
    );
        logic signed [XW-1:0] s;
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    // Subtracting the shifted value moves v toward zero, so the result
    // always fits in the original width.
    function automatic logic signed [XW-1:0] leak(
        input logic signed [XW-1:0] v,
        input int                   shift
    );
        return v - (v >>> shift);
    endfunction

endpackage

// File: rtl/lif_neuron_update.sv
// Combinational next-state of one neuron for a leak/fire sweep step.
//   v, ref_cnt   : stored potential and refractory count
//   threshold    : signed firing threshold
//   v_next       : potential to write back
//   ref_next     : refractory count to write back
//   fire         : neuron spikes this step
module lif_neuron_update
    import snn_neuron_pkg::*;
#(
    parameter int W           = 32,
    parameter int DECAY_SHIFT = 3,
    parameter int REFRACTORY  = 2,
    parameter int V_RESET     = 0,
    parameter int RW          = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1
) (
    input  logic signed [W-1:0]  v,
    input  logic        [RW-1:0] ref_cnt,
    input  logic signed [W-1:0]  threshold,
    output logic signed [W-1:0]  v_next,
    output logic        [RW-1:0] ref_next,
    output logic                 fire
);

    localparam logic signed [W-1:0] V_RST = W'(V_RESET);

    function automatic logic signed [XW-1:0] sext(input logic signed [W-1:0] a);
        return {{(XW-W){a[W-1]}}, a};
    endfunction

    logic signed [W-1:0] d;

    assign d = W'(leak(sext(v), DECAY_SHIFT));

    always_comb begin
        v_next   = d;
        ref_next = ref_cnt;
        fire     = 1'b0;
        if (ref_cnt != '0) begin
            // Held neurons are clamped to rest and count down.
            v_next   = V_RST;
            ref_next = ref_cnt - 1'b1;
        end else if (d >= threshold) begin
            v_next   = V_RST;
            ref_next = RW'(REFRACTORY);
            fire     = 1'b1;
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons.
// Input events accumulate (saturating) into per-neuron potentials while
// idle; a time_step pulse sweeps all neurons once applying leak, fire and
// refractory handling, stalling on each spike until the encoder takes it.
//   CLK, RESET              : clock, synchronous active-high reset
//   v_threshold             : shared signed firing threshold
//   in_valid/in_ready       : input event handshake (in_id, in_weight)
//   time_step               : starts a sweep; step_overrun if busy
//   out_valid/out_ready     : spike handshake (out_id)
//   sweep_done              : one-cycle pulse at end of sweep
//   rd_id/rd_potential      : combinational debug read
module lif_neuron_array
    import snn_neuron_pkg::*;
#(
    parameter int N_NEURONS   = 16,
    parameter int W           = 32,
    parameter int DECAY_SHIFT = 3,
    parameter int REFRACTORY  = 2,
    parameter int V_RESET     = 0,
    localparam int IDW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int RW  = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic signed [W-1:0]  v_threshold,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IDW-1:0]       in_id,
    input  logic signed [W-1:0]  in_weight,
    input  logic                 time_step,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDW-1:0]       out_id,
    output logic                 sweep_done,
    output logic                 step_overrun,
    input  logic [IDW-1:0]       rd_id,
    output logic signed [W-1:0]  rd_potential
);

    localparam logic signed [W-1:0] V_RST = W'(V_RESET);

    function automatic logic signed [XW-1:0] sext(input logic signed [W-1:0] a);
        return {{(XW-W){a[W-1]}}, a};
    endfunction

    state_t                        state_q, state_d;
    logic [IDW-1:0]                idx_q, idx_d;
    logic                          done_d;
    logic [N_NEURONS-1:0][W-1:0]   v_q, upd_v;
    logic [N_NEURONS-1:0][RW-1:0]  ref_q, upd_ref;
    logic [N_NEURONS-1:0]          upd_fire;
    logic                          sel_fire, last;
    logic [IDW-1:0]                out_id_q;
    logic                          sweep_done_q, overrun_q;
    logic signed [W-1:0]           acc_cur, acc_next;

    assign last     = (idx_q == IDW'(N_NEURONS - 1));
    assign sel_fire = upd_fire[idx_q];
    assign acc_cur  = v_q[in_id];
    assign acc_next = W'(sat_add(sext(acc_cur), sext(in_weight), W));

    assign out_id       = out_id_q;
    assign sweep_done   = sweep_done_q;
    assign step_overrun = overrun_q;
    assign rd_potential = v_q[rd_id];

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
        lif_neuron_update #(
            .W           (W),
            .DECAY_SHIFT (DECAY_SHIFT),
            .REFRACTORY  (REFRACTORY),
            .V_RESET     (V_RESET),
            .RW          (RW)
        ) u_upd (
            .v         (v_q[g]),
            .ref_cnt   (ref_q[g]),
            .threshold (v_threshold),
            .v_next    (upd_v[g]),
            .ref_next  (upd_ref[g]),
            .fire      (upd_fire[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_ACCUM;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (time_step) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (sel_fire) begin
                    state_d = ST_SPIKE_WAIT;
                end else if (last) begin
                    done_d  = 1'b1;
                    state_d = ST_ACCUM;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SPIKE_WAIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = ST_ACCUM;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SWEEP;
                    end
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v_q          <= {N_NEURONS{V_RST}};
            ref_q        <= '0;
            out_id_q     <= '0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sweep_done_q <= done_d;
            overrun_q    <= time_step && (state_q != ST_ACCUM);
            // Events to a refractory neuron are accepted but dropped.
            if (state_q == ST_ACCUM && in_valid && ref_q[in_id] == '0) begin
                v_q[in_id] <= acc_next;
            end
            if (state_q == ST_SWEEP) begin
                v_q[idx_q]   <= upd_v[idx_q];
                ref_q[idx_q] <= upd_ref[idx_q];
                if (sel_fire) out_id_q <= idx_q;
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
module tb_lif_neuron_array;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;

    logic                CLK = 1'b0;
    logic                RESET;
    logic signed [W-1:0] v_threshold;
    logic                in_valid, in_ready;
    logic [IDW-1:0]      in_id;
    logic signed [W-1:0] in_weight;
    logic                time_step;
    logic                out_valid, out_ready;
    logic [IDW-1:0]      out_id;
    logic                sweep_done, step_overrun;
    logic [IDW-1:0]      rd_id;
    logic signed [W-1:0] rd_potential;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 CLK = ~CLK;

    lif_neuron_array #(
        .N_NEURONS(N), .W(W), .DECAY_SHIFT(1), .REFRACTORY(2), .V_RESET(0)
    ) dut (
        .CLK(CLK), .RESET(RESET), .v_threshold(v_threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_weight(in_weight),
        .time_step(time_step), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .sweep_done(sweep_done), .step_overrun(step_overrun),
        .rd_id(rd_id), .rd_potential(rd_potential)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic send(input int id, input int w);
        in_valid  = 1'b1;
        in_id     = IDW'(id);
        in_weight = W'(w);
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic step();
        time_step = 1'b1;
        tick();
        time_step = 1'b0;
    endtask

    task automatic chk_rd(input string name, input int id, input longint exp);
        rd_id = IDW'(id);
        #1;
        check(name, longint'(rd_potential), exp);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (sweep_done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (sweep_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL sweep_done_timeout: got no pulse in %0d cycles expected pulse", n);
        end
    endtask

    // Spike monitor: pops the expected ID on every handshake and checks
    // that a stalled spike keeps its ID.
    initial begin
        logic          stall_prev = 1'b0;
        logic [IDW-1:0] hold_id   = '0;
        forever begin
            @(negedge CLK);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spike_unexpected: got id %0d expected none", out_id);
                end else begin
                    check("spike_id", longint'(out_id), longint'(exp_q.pop_front()));
                end
            end
            if (stall_prev && out_valid) check("spike_hold", longint'(out_id), longint'(hold_id));
            stall_prev = out_valid && !out_ready;
            hold_id    = out_id;
        end
    end

    initial begin
        int n;
        int bad;
        RESET = 1'b1; in_valid = 1'b0; in_id = '0; in_weight = '0;
        time_step = 1'b0; out_ready = 1'b1; rd_id = '0; v_threshold = 16'sd100;
        tick(); tick();
        RESET = 1'b0;

        // reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_overrun", step_overrun, 0);
        check("rst_out_id", out_id, 0);
        for (int i = 0; i < N; i++) chk_rd("rst_v", i, 0);

        // sub-threshold leak
        send(1, 60); send(1, 60);
        chk_rd("acc_v1", 1, 120);
        step();
        check("sweep_in_ready", in_ready, 0);
        wait_done(n);
        check("leak_cycles", n, 4);
        check("done_in_ready", in_ready, 1);
        chk_rd("leak_v1", 1, 60);

        // fire and refractory
        do_reset();
        send(2, 250);
        exp_q.push_back(2);
        step(); wait_done(n);
        check("fire_cycles", n, 5);
        chk_rd("fire_v2", 2, 0);
        for (int k = 0; k < 2; k++) begin
            send(2, 300);
            chk_rd("refr_drop", 2, 0);
            step(); wait_done(n);
            check("refr_cycles", n, 4);
            chk_rd("refr_v2", 2, 0);
        end
        send(2, 300);
        chk_rd("refr_over_v2", 2, 300);
        exp_q.push_back(2);
        step(); wait_done(n);
        chk_rd("refire_v2", 2, 0);

        // saturation
        do_reset();
        send(0, 30000);
        chk_rd("sat_v0_a", 0, 30000);
        send(0, 30000);
        chk_rd("sat_v0_b", 0, 32767);
        send(3, -32768);
        chk_rd("sat_v3_a", 3, -32768);
        send(3, -32768); send(3, -32768);
        chk_rd("sat_v3_b", 3, -32768);

        // backpressure
        do_reset();
        send(0, 250); send(3, 250);
        out_ready = 1'b0;
        exp_q.push_back(0); exp_q.push_back(3);
        step();
        check("bp_not_yet_valid", out_valid, 0);
        tick();
        check("bp_valid", out_valid, 1);
        check("bp_id0", out_id, 0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid !== 1'b1 || out_id !== 2'd0 || sweep_done !== 1'b0) bad++;
        end
        check("bp_stall", bad, 0);
        out_ready = 1'b1;
        wait_done(n);
        check("bp_queue", exp_q.size(), 0);
        chk_rd("bp_v0", 0, 0);
        chk_rd("bp_v3", 3, 0);

        // overrun
        do_reset();
        step();
        time_step = 1'b1;
        tick();
        time_step = 1'b0;
        check("overrun_pulse", step_overrun, 1);
        tick();
        check("overrun_clear", step_overrun, 0);
        wait_done(n);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (in_ready !== 1'b1 || sweep_done !== 1'b0 || step_overrun !== 1'b0) bad++;
        end
        check("no_second_sweep", bad, 0);

        // reset during SPIKE_WAIT
        do_reset();
        send(1, 250); send(2, 50);
        out_ready = 1'b0;
        step(); tick(); tick();
        check("mid_valid", out_valid, 1);
        check("mid_id", out_id, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        for (int i = 0; i < N; i++) chk_rd("mid_rst_v", i, 0);
        out_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        check("mid_no_spike", bad, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
